// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: instruction encodings,
// loader state encoding, fetch output selection and the NOP word.
package imem_loader_pkg;

    localparam int M_DEF = 4;
    localparam int P_DEF = 6;
    localparam int W_DEF = 4 + 2 * M_DEF;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_LD  = 4'h4,
        OP_ST  = 4'h5,
        OP_JMP = 4'h6,
        OP_NOP = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_RUN,
        ST_ERROR
    } loader_state_t;

    // Source driving instruction_out after each fetch edge.
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_NOP,
        SEL_MEM
    } fetch_sel_t;

    localparam logic [W_DEF-1:0] NOP_WORD = {OP_NOP, {(2 * M_DEF){1'b0}}};

endpackage

// File: rtl/imem_loader_sp_ram.sv
// Simple dual-port instruction RAM: one synchronous write port and one
// synchronous read port with enable; read data holds while re is low.
module imem_sp_ram #(
    parameter int DW = 12,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory responder with a word-serial program load port; holds the
// CPU in reset until a complete program is resident.
//
// Load handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high; load_data/load_last are sampled on that edge only.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int M = 4,
    parameter int P = 6,
    parameter int W = 4 + 2 * M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_read_instr,
    input  logic [P-1:0] read_address_instr,
    output logic [W-1:0] instruction_out,
    input  logic         load_start,
    input  logic         load_valid,
    input  logic         load_last,
    input  logic [W-1:0] load_data,
    output logic         load_ready,
    output logic         cpu_rst_n,
    output logic         load_done,
    output logic         load_error
);

    localparam int DEPTH = 1 << P;
    localparam logic [W-1:0] NOP_W = {OP_NOP, {(W - 4){1'b0}}};

    loader_state_t state, state_next;
    fetch_sel_t    fetch_sel;
    logic [P-1:0]  wr_addr;
    logic [P:0]    word_count;
    logic          accept;
    logic          fetch_hit;
    logic [W-1:0]  ram_rdata;

    assign accept    = (state == ST_LOADING) && load_valid;
    assign fetch_hit = ({1'b0, read_address_instr} < word_count);

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (load_start) state_next = ST_LOADING;
            end
            ST_LOADING: begin
                // load_start is deliberately ignored mid-load.
                if (accept) begin
                    if (load_last) begin
                        state_next = ST_RUN;
                    end else if (wr_addr == P'(DEPTH - 1)) begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) state_next = ST_LOADING;
            end
            ST_ERROR: begin
                if (load_start) state_next = ST_LOADING;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            wr_addr    <= '0;
            word_count <= '0;
            load_ready <= 1'b0;
            cpu_rst_n  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_next;
            load_ready <= (state_next == ST_LOADING);
            cpu_rst_n  <= (state_next == ST_RUN);
            load_done  <= (state_next == ST_RUN);
            load_error <= (state_next == ST_ERROR);
            if ((state != ST_LOADING) && (state_next == ST_LOADING)) begin
                wr_addr <= '0;
            end else if (accept) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (accept && load_last) begin
                word_count <= {1'b0, wr_addr} + (P + 1)'(1);
            end
        end
    end

    // Output select is registered alongside the RAM read so both line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_sel <= SEL_ZERO;
        end else if (state != ST_RUN) begin
            fetch_sel <= SEL_ZERO;
        end else if (en_read_instr) begin
            fetch_sel <= fetch_hit ? SEL_MEM : SEL_NOP;
        end
    end

    imem_sp_ram #(
        .DW(W),
        .AW(P)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_addr),
        .wdata (load_data),
        .re    (en_read_instr && (state == ST_RUN) && fetch_hit),
        .raddr (read_address_instr),
        .rdata (ram_rdata)
    );

    always_comb begin
        instruction_out = '0;
        case (fetch_sel)
            SEL_MEM:  instruction_out = ram_rdata;
            SEL_NOP:  instruction_out = NOP_W;
            default:  instruction_out = '0;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, fetch, overflow, reload and mid-load reset.
module tb_imem_loader;

    localparam int M = 4;
    localparam int P = 6;
    localparam int W = 12;
    localparam logic [W-1:0] NOP = 12'hF00;

    logic         clk;
    logic         rst_n;
    logic         en_read_instr;
    logic [P-1:0] read_address_instr;
    logic [W-1:0] instruction_out;
    logic         load_start;
    logic         load_valid;
    logic         load_last;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         cpu_rst_n;
    logic         load_done;
    logic         load_error;

    int checks;
    int failures;

    imem_loader #(.M(M), .P(P), .W(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .en_read_instr      (en_read_instr),
        .read_address_instr (read_address_instr),
        .instruction_out    (instruction_out),
        .load_start         (load_start),
        .load_valid         (load_valid),
        .load_last          (load_last),
        .load_data          (load_data),
        .load_ready         (load_ready),
        .cpu_rst_n          (cpu_rst_n),
        .load_done          (load_done),
        .load_error         (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are observed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] data, input logic last);
        int waited;
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        waited = 0;
        while (load_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_word_timeout: load_ready=%b required 1", load_ready);
        end
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [P-1:0] addr);
        en_read_instr      = 1'b1;
        read_address_instr = addr;
        step();
        en_read_instr      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_read_instr = 1'b0; read_address_instr = '0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        #12;
        checks++;
        if ({instruction_out, load_ready, cpu_rst_n, load_done, load_error} !== {12'h000, 4'b0000}) begin
            failures++;
            $display("FAIL reset_values: instr=%h ready=%b cpu_rst_n=%b done=%b err=%b required all 0",
                     instruction_out, load_ready, cpu_rst_n, load_done, load_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (load_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL empty_idle: ready=%b cpu_rst_n=%b required 0 0", load_ready, cpu_rst_n);
        end
    endtask

    task automatic test_load3();
        logic [W-1:0] words [3];
        int ready_cycles;
        words[0] = 12'h123; words[1] = 12'h456; words[2] = 12'h789;
        pulse_start();
        ready_cycles = 0;
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_data = words[i];
            load_last = (i == 2);
            if (load_ready === 1'b1) ready_cycles++;
            checks++;
            if (cpu_rst_n !== 1'b0) begin
                failures++;
                $display("FAIL load3_cpu_held word=%0d: cpu_rst_n=%b required 0", i, cpu_rst_n);
            end
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        checks++;
        if (ready_cycles != 3) begin
            failures++;
            $display("FAIL load3_ready_cycles: got %0d required 3", ready_cycles);
        end
        checks++;
        if ({load_ready, cpu_rst_n, load_done, load_error} !== 4'b0110) begin
            failures++;
            $display("FAIL load3_run: ready=%b cpu_rst_n=%b done=%b err=%b required 0 1 1 0",
                     load_ready, cpu_rst_n, load_done, load_error);
        end
    endtask

    task automatic test_fetch();
        logic [W-1:0] exp [4];
        exp[0] = 12'h123; exp[1] = 12'h456; exp[2] = 12'h789; exp[3] = NOP;
        en_read_instr = 1'b1;
        for (int a = 0; a < 4; a++) begin
            read_address_instr = P'(a);
            step();
            checks++;
            if (instruction_out !== exp[a]) begin
                failures++;
                $display("FAIL fetch_addr%0d: got %h required %h", a, instruction_out, exp[a]);
            end
        end
        read_address_instr = 6'd2;
        step();
        en_read_instr = 1'b0;
        read_address_instr = 6'd0;
        step();
        step();
        checks++;
        if (instruction_out !== 12'h789) begin
            failures++;
            $display("FAIL fetch_hold: got %h required 789", instruction_out);
        end
    endtask

    task automatic test_valid_toggle();
        logic [W-1:0] data_seq [5];
        logic         vld_seq  [5];
        logic [W-1:0] exp [4];
        data_seq[0] = 12'h111; vld_seq[0] = 1'b1;
        data_seq[1] = 12'hEEE; vld_seq[1] = 1'b0;
        data_seq[2] = 12'h222; vld_seq[2] = 1'b1;
        data_seq[3] = 12'hDDD; vld_seq[3] = 1'b0;
        data_seq[4] = 12'h333; vld_seq[4] = 1'b1;
        exp[0] = 12'h111; exp[1] = 12'h222; exp[2] = 12'h333; exp[3] = NOP;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            load_valid = vld_seq[i];
            load_data  = data_seq[i];
            load_last  = (i == 4);
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        checks++;
        if (load_done !== 1'b1) begin
            failures++;
            $display("FAIL toggle_done: load_done=%b required 1", load_done);
        end
        for (int a = 0; a < 4; a++) begin
            fetch(P'(a));
            checks++;
            if (instruction_out !== exp[a]) begin
                failures++;
                $display("FAIL toggle_readback%0d: got %h required %h", a, instruction_out, exp[a]);
            end
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send_word(W'(i + 12'h400), 1'b0);
            if (i == 62) begin
                checks++;
                if (load_error !== 1'b0) begin
                    failures++;
                    $display("FAIL overflow_early: load_error=%b required 0 after 63 words", load_error);
                end
            end
        end
        checks++;
        if ({load_error, cpu_rst_n, load_done, load_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL overflow_error: err=%b cpu_rst_n=%b done=%b ready=%b required 1 0 0 0",
                     load_error, cpu_rst_n, load_done, load_ready);
        end
        pulse_start();
        checks++;
        if (load_error !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL overflow_clear: err=%b ready=%b required 0 1", load_error, load_ready);
        end
        send_word(12'h5A5, 1'b1);
        checks++;
        if (cpu_rst_n !== 1'b1 || load_done !== 1'b1) begin
            failures++;
            $display("FAIL overflow_recover: cpu_rst_n=%b done=%b required 1 1", cpu_rst_n, load_done);
        end
        fetch(6'd0);
        checks++;
        if (instruction_out !== 12'h5A5) begin
            failures++;
            $display("FAIL overflow_fetch0: got %h required 5a5", instruction_out);
        end
        fetch(6'd1);
        checks++;
        if (instruction_out !== NOP) begin
            failures++;
            $display("FAIL overflow_fetch1: got %h required %h", instruction_out, NOP);
        end
    endtask

    task automatic test_reload();
        pulse_start();
        checks++;
        if (cpu_rst_n !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL reload_enter: cpu_rst_n=%b done=%b required 0 0", cpu_rst_n, load_done);
        end
        fetch(6'd0);
        checks++;
        if (instruction_out !== 12'h000) begin
            failures++;
            $display("FAIL reload_fetch_blocked: got %h required 000", instruction_out);
        end
        send_word(12'h321, 1'b0);
        send_word(12'h654, 1'b1);
        fetch(6'd0);
        checks++;
        if (instruction_out !== 12'h321) begin
            failures++;
            $display("FAIL reload_fetch0: got %h required 321", instruction_out);
        end
        fetch(6'd1);
        checks++;
        if (instruction_out !== 12'h654) begin
            failures++;
            $display("FAIL reload_fetch1: got %h required 654", instruction_out);
        end
        fetch(6'd2);
        checks++;
        if (instruction_out !== NOP) begin
            failures++;
            $display("FAIL reload_fetch2: got %h required %h", instruction_out, NOP);
        end
    endtask

    task automatic test_reset_midload();
        pulse_start();
        send_word(12'hAAA, 1'b0);
        send_word(12'hBBB, 1'b0);
        #2;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({instruction_out, load_ready, cpu_rst_n, load_done, load_error} !== {12'h000, 4'b0000}) begin
            failures++;
            $display("FAIL midload_reset: instr=%h ready=%b cpu_rst_n=%b done=%b err=%b required all 0",
                     instruction_out, load_ready, cpu_rst_n, load_done, load_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pulse_start();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL midload_restart: load_ready=%b required 1", load_ready);
        end
        send_word(12'h777, 1'b1);
        fetch(6'd0);
        checks++;
        if (instruction_out !== 12'h777) begin
            failures++;
            $display("FAIL midload_fetch0: got %h required 777", instruction_out);
        end
        fetch(6'd1);
        checks++;
        if (instruction_out !== NOP) begin
            failures++;
            $display("FAIL midload_fetch1: got %h required %h", instruction_out, NOP);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_load3();
        test_fetch();
        test_valid_toggle();
        test_overflow();
        test_reload();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
